// File: rtl/logic_chk_pkg.sv
// logic_chk_pkg: operation codes, checker FSM states and golden helpers for logic_vec_checker harnesses.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
//
// Contents:
//   OP_*        operation codes selecting the golden function
//   chk_state_t checker FSM state encoding
//   LFSR_POLY   toggle mask of the 32-bit right-shifting Galois LFSR
//   logic_ref   golden two-input bitwise result, 32 bits wide (callers truncate)
//   lfsr_next   one LFSR step
package logic_chk_pkg;

  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_XNOR = 3;
  localparam int OP_NAND = 4;
  localparam int OP_NOR  = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Unknown op codes yield zero so a bad OP shows up as mismatches rather than silently passing.
  function automatic logic [31:0] logic_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Right-shifting Galois form: the bit shifted out decides whether the mask is applied.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/lfsr32.sv
// lfsr32: 32-bit Galois LFSR operand generator with synchronous reload.
// Latency: q reflects load/step one cycle after they are sampled.
// Backpressure: none; advances only when step is high, load takes priority over step.
//
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset, loads RESET_SEED
//   load   reload q with seed this cycle
//   seed   value loaded on load
//   step   advance one LFSR step this cycle
//   q      current LFSR state
module lfsr32
  import logic_chk_pkg::*;
#(
  parameter logic [31:0] RESET_SEED = 32'hACE1_0001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= RESET_SEED;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/logic_vec_checker.sv
// logic_vec_checker: drives a directed vector then LFSR vectors into a bitwise logic DUT and checks its result.
// Latency: vector i is presented from edge i and compared at edge i+1+LAT; finish rises at edge NUM_VEC+LAT.
// Backpressure: none; one vector per cycle, start is ignored while busy.
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   start          one-cycle run request (honoured in IDLE or DONE)
//   a, b           registered operands to the DUT
//   y              DUT result, expected LAT cycles after the operands
//   busy           high while driving or draining
//   fail           sticky mismatch flag for the current run
//   finish         sticky run-complete flag
//   err_count      saturating mismatch count for the current run
//   first_err_idx  index of the first mismatching vector, 0 if none
module logic_vec_checker
  import logic_chk_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int          NUM_VEC = 16,
  parameter int          LAT     = 0,
  parameter int          OP      = OP_XNOR,
  parameter logic [31:0] A0      = 32'd3,
  parameter logic [31:0] B0      = 32'd12,
  parameter logic [31:0] SEED    = 32'hACE1_0001
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             fail,
  output logic             finish,
  output logic [15:0]      err_count,
  output logic [15:0]      first_err_idx
);

  localparam logic [15:0] LAST_IDX   = 16'(NUM_VEC - 1);
  localparam logic [2:0]  DRAIN_INIT = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

  chk_state_t       state;
  logic [15:0]      cur_idx;    // index of the vector currently on a/b
  logic [2:0]       drain_cnt;
  logic [31:0]      lfsr_q;
  logic             start_run;
  logic             lfsr_step;

  // Stage 0 of the expected-result line: what the DUT should produce for the operands on a/b now.
  logic             s0_vld;
  logic [WIDTH-1:0] s0_exp;
  logic [15:0]      s0_idx;

  // Tail of the expected-result line, lined up with y.
  logic             cmp_vld;
  logic [WIDTH-1:0] cmp_exp;
  logic [15:0]      cmp_idx;
  logic             mismatch;

  assign start_run = start && ((state == ST_IDLE) || (state == ST_DONE));

  // Vector 1 uses the seed itself, so the LFSR advances as each random vector is consumed.
  assign lfsr_step = (state == ST_DRIVE) && (cur_idx != LAST_IDX);

  lfsr32 #(
    .RESET_SEED(SEED)
  ) u_lfsr (
    .clock (clock),
    .reset (reset),
    .load  (start_run),
    .seed  (SEED),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  // ------------------------------------------------------------------
  // Control FSM and operand registers
  // ------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cur_idx   <= 16'd0;
      drain_cnt <= 3'd0;
      a         <= '0;
      b         <= '0;
      busy      <= 1'b0;
      finish    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_DRIVE;
            cur_idx <= 16'd0;
            a       <= WIDTH'(A0);
            b       <= WIDTH'(B0);
            busy    <= 1'b1;
            finish  <= 1'b0;
          end
        end

        ST_DRIVE: begin
          if (cur_idx == LAST_IDX) begin
            // a/b keep the last vector; only the pipeline tail remains to be checked.
            if (LAT > 0) begin
              state     <= ST_DRAIN;
              drain_cnt <= DRAIN_INIT;
            end else begin
              state  <= ST_DONE;
              busy   <= 1'b0;
              finish <= 1'b1;
            end
          end else begin
            cur_idx <= cur_idx + 16'd1;
            a       <= WIDTH'(lfsr_q);
            b       <= lfsr_q[31 -: WIDTH];
          end
        end

        ST_DRAIN: begin
          if (drain_cnt == 3'd0) begin
            state  <= ST_DONE;
            busy   <= 1'b0;
            finish <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Expected-result line
  // ------------------------------------------------------------------
  assign s0_vld = (state == ST_DRIVE);
  assign s0_exp = WIDTH'(logic_ref(OP, 32'(a), 32'(b)));
  assign s0_idx = cur_idx;

  generate
    if (LAT == 0) begin : g_bypass
      assign cmp_vld = s0_vld;
      assign cmp_exp = s0_exp;
      assign cmp_idx = s0_idx;
    end else begin : g_pipe
      logic             pipe_vld [LAT];
      logic [WIDTH-1:0] pipe_exp [LAT];
      logic [15:0]      pipe_idx [LAT];

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < LAT; k++) begin
            pipe_vld[k] <= 1'b0;
            pipe_exp[k] <= '0;
            pipe_idx[k] <= 16'd0;
          end
        end else begin
          pipe_vld[0] <= s0_vld;
          pipe_exp[0] <= s0_exp;
          pipe_idx[0] <= s0_idx;
          for (int k = 1; k < LAT; k++) begin
            pipe_vld[k] <= pipe_vld[k-1];
            pipe_exp[k] <= pipe_exp[k-1];
            pipe_idx[k] <= pipe_idx[k-1];
          end
        end
      end

      assign cmp_vld = pipe_vld[LAT-1];
      assign cmp_exp = pipe_exp[LAT-1];
      assign cmp_idx = pipe_idx[LAT-1];
    end
  endgenerate

  // ------------------------------------------------------------------
  // Result tracking
  // ------------------------------------------------------------------
  assign mismatch = cmp_vld && (y != cmp_exp);

  // A run start never coincides with a live compare: the line is empty in IDLE/DONE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fail          <= 1'b0;
      err_count     <= 16'd0;
      first_err_idx <= 16'd0;
    end else if (start_run) begin
      fail          <= 1'b0;
      err_count     <= 16'd0;
      first_err_idx <= 16'd0;
    end else if (mismatch) begin
      fail <= 1'b1;
      if (!fail) begin
        first_err_idx <= cmp_idx;
      end
      if (err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_logic_vec_checker.sv
module tb_logic_vec_checker;
  import logic_chk_pkg::*;

  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference operand sequences (WIDTH=32 for u_b, WIDTH=16 for u_c).
  logic [31:0] va_b [16];
  logic [31:0] vb_b [16];
  logic [15:0] va_c [16];
  logic [15:0] vb_c [16];

  // ---------------- u_a: 8-bit XNOR, combinational DUT ----------------
  logic        start_a = 1'b0;
  logic        inj_a   = 1'b0;
  logic [7:0]  a_a, b_a, y_a;
  logic        busy_a, fail_a, finish_a;
  logic [15:0] err_a, idx_a;

  logic_vec_checker #(.WIDTH(8), .NUM_VEC(1), .LAT(0), .OP(OP_XNOR)) u_a (
    .clock(clock), .reset(reset), .start(start_a), .a(a_a), .b(b_a), .y(y_a),
    .busy(busy_a), .fail(fail_a), .finish(finish_a), .err_count(err_a), .first_err_idx(idx_a)
  );
  assign y_a = ~(a_a ^ b_a) | {7'd0, inj_a};

  // ---------------- u_b: 32-bit NAND, 3-stage DUT ----------------
  logic        start_b = 1'b0;
  logic        inj_b [16] = '{default: 1'b0};
  logic [31:0] a_b, b_b, y_b;
  logic [31:0] pb0 = '0, pb1 = '0, pb2 = '0;
  logic        busy_b, fail_b, finish_b;
  logic [15:0] err_b, idx_b;

  logic_vec_checker #(.WIDTH(32), .NUM_VEC(16), .LAT(3), .OP(OP_NAND)) u_b (
    .clock(clock), .reset(reset), .start(start_b), .a(a_b), .b(b_b), .y(y_b),
    .busy(busy_b), .fail(fail_b), .finish(finish_b), .err_count(err_b), .first_err_idx(idx_b)
  );

  always @(posedge clock) begin
    logic flip;
    flip = 1'b0;
    for (int i = 0; i < 16; i++)
      if (inj_b[i] && a_b == va_b[i] && b_b == vb_b[i]) flip = 1'b1;
    pb0 <= ~(a_b & b_b) ^ {31'd0, flip};
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign y_b = pb2;

  // ---------------- u_c: 16-bit OR, checker expects LAT=2, DUT has 1 ----------------
  logic        start_c = 1'b0;
  logic [15:0] a_c, b_c;
  logic [15:0] y_c = '0;
  logic        busy_c, fail_c, finish_c;
  logic [15:0] err_c, idx_c;

  logic_vec_checker #(.WIDTH(16), .NUM_VEC(16), .LAT(2), .OP(OP_OR)) u_c (
    .clock(clock), .reset(reset), .start(start_c), .a(a_c), .b(b_c), .y(y_c),
    .busy(busy_c), .fail(fail_c), .finish(finish_c), .err_count(err_c), .first_err_idx(idx_c)
  );
  always @(posedge clock) y_c <= a_c | b_c;

  // Vector 0 is (3,12); vector i>=1 is the LFSR state after i-1 steps from SEED.
  task automatic build_model();
    logic [31:0] s;
    s = SEED;
    va_b[0] = 32'd3;  vb_b[0] = 32'd12;
    va_c[0] = 16'd3;  vb_c[0] = 16'd12;
    for (int i = 1; i < 16; i++) begin
      va_b[i] = s;         vb_b[i] = s;
      va_c[i] = s[15:0];   vb_c[i] = s[31:16];
      s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_vec++;
    if ({a_a, b_a, busy_a, fail_a, finish_a, err_a, idx_a} !== '0) begin
      n_err++; $display("FAIL reset_a: got a=%h b=%h busy=%b fail=%b fin=%b err=%0d idx=%0d, want all 0",
                        a_a, b_a, busy_a, fail_a, finish_a, err_a, idx_a);
    end
    n_vec++;
    if ({a_b, b_b, busy_b, fail_b, finish_b, err_b, idx_b} !== '0) begin
      n_err++; $display("FAIL reset_b: got a=%h b=%h busy=%b fail=%b fin=%b err=%0d idx=%0d, want all 0",
                        a_b, b_b, busy_b, fail_b, finish_b, err_b, idx_b);
    end
    n_vec++;
    if ({a_c, b_c, busy_c, fail_c, finish_c, err_c, idx_c} !== '0) begin
      n_err++; $display("FAIL reset_c: got a=%h b=%h busy=%b fail=%b fin=%b err=%0d idx=%0d, want all 0",
                        a_c, b_c, busy_c, fail_c, finish_c, err_c, idx_c);
    end
    reset = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clock);
    n_vec++;
    if ({busy_b, finish_b, a_b} !== '0) begin
      n_err++; $display("FAIL idle_b: got busy=%b fin=%b a=%h, want 0 0 0", busy_b, finish_b, a_b);
    end
  endtask

  task automatic test_xnor_clean();
    @(negedge clock) start_a = 1'b1;
    @(negedge clock) start_a = 1'b0;   // after edge 0
    n_vec++;
    if (a_a !== 8'h03 || b_a !== 8'h0C || busy_a !== 1'b1 || finish_a !== 1'b0) begin
      n_err++; $display("FAIL xnor_edge0: got a=%h b=%h busy=%b fin=%b, want 03 0c 1 0", a_a, b_a, busy_a, finish_a);
    end
    @(negedge clock);                  // after edge 1
    n_vec++;
    if (finish_a !== 1'b1 || busy_a !== 1'b0) begin
      n_err++; $display("FAIL xnor_finish: got fin=%b busy=%b, want 1 0", finish_a, busy_a);
    end
    n_vec++;
    if (fail_a !== 1'b0 || err_a !== 16'd0 || idx_a !== 16'd0) begin
      n_err++; $display("FAIL xnor_clean: got fail=%b err=%0d idx=%0d, want 0 0 0", fail_a, err_a, idx_a);
    end
  endtask

  task automatic test_xnor_inject();
    inj_a = 1'b1;
    repeat ($urandom_range(0, 2)) @(negedge clock);
    @(negedge clock) start_a = 1'b1;
    @(negedge clock) start_a = 1'b0;
    @(negedge clock);
    n_vec++;
    if (fail_a !== 1'b1 || err_a !== 16'd1 || idx_a !== 16'd0 || finish_a !== 1'b1) begin
      n_err++; $display("FAIL xnor_inject: got fail=%b err=%0d idx=%0d fin=%b, want 1 1 0 1",
                        fail_a, err_a, idx_a, finish_a);
    end
    inj_a = 1'b0;
  endtask

  task automatic test_nand_lat3();
    int kk;
    int busy_cycles;
    kk = $urandom_range(2, 12);
    busy_cycles = 0;
    @(negedge clock) start_b = 1'b1;
    @(negedge clock) start_b = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      int vi;
      vi = (k < 16) ? k : 15;
      if (busy_b) busy_cycles++;
      n_vec++;
      if (a_b !== va_b[vi] || b_b !== vb_b[vi]) begin
        n_err++; $display("FAIL nand_vec k=%0d: got a=%h b=%h, want a=%h b=%h", k, a_b, b_b, va_b[vi], vb_b[vi]);
      end
      n_vec++;
      if (finish_b !== (k >= 19)) begin
        n_err++; $display("FAIL nand_finish k=%0d: got %b, want %b", k, finish_b, (k >= 19));
      end
      start_b = (k == kk);             // mid-run start must be ignored
      @(negedge clock);
    end
    start_b = 1'b0;
    n_vec++;
    if (busy_cycles != 19) begin
      n_err++; $display("FAIL nand_busy: got %0d busy cycles, want 19", busy_cycles);
    end
    n_vec++;
    if (fail_b !== 1'b0 || err_b !== 16'd0 || idx_b !== 16'd0) begin
      n_err++; $display("FAIL nand_clean: got fail=%b err=%0d idx=%0d, want 0 0 0", fail_b, err_b, idx_b);
    end
  endtask

  task automatic test_wrong_latency();
    int  exp_err;
    int  exp_first;
    bit  seen;
    exp_err = 0; exp_first = 0; seen = 0;
    // A one-cycle-early DUT shows vector i+1's result when vector i is checked; the last vector is held.
    for (int i = 0; i < 15; i++) begin
      if ((va_c[i] | vb_c[i]) != (va_c[i+1] | vb_c[i+1])) begin
        if (!seen) exp_first = i;
        seen = 1'b1;
        exp_err++;
      end
    end
    @(negedge clock) start_c = 1'b1;
    @(negedge clock) start_c = 1'b0;
    repeat (20) @(negedge clock);
    n_vec++;
    if (finish_c !== 1'b1 || fail_c !== 1'b1) begin
      n_err++; $display("FAIL wronglat_flags: got fin=%b fail=%b, want 1 1", finish_c, fail_c);
    end
    n_vec++;
    if (err_c !== 16'(exp_err) || err_c < 16'd14) begin
      n_err++; $display("FAIL wronglat_count: got %0d, want %0d (at least 14)", err_c, exp_err);
    end
    n_vec++;
    if (idx_c !== 16'(exp_first)) begin
      n_err++; $display("FAIL wronglat_first: got %0d, want %0d", idx_c, exp_first);
    end
  endtask

  task automatic test_reset_midrun();
    int busy_cycles;
    @(negedge clock) start_b = 1'b1;
    @(negedge clock) start_b = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      n_vec++;
      if (a_b !== va_b[k] || b_b !== vb_b[k]) begin
        n_err++; $display("FAIL midrun_vec k=%0d: got a=%h b=%h, want a=%h b=%h", k, a_b, b_b, va_b[k], vb_b[k]);
      end
      if (k < 4) @(negedge clock);
    end
    @(posedge clock);                  // edge 5
    #1 reset = 1'b0;
    #1;
    n_vec++;
    if ({a_b, b_b, busy_b, fail_b, finish_b, err_b, idx_b} !== '0) begin
      n_err++; $display("FAIL midrun_reset: got a=%h b=%h busy=%b fail=%b fin=%b err=%0d idx=%0d, want all 0",
                        a_b, b_b, busy_b, fail_b, finish_b, err_b, idx_b);
    end
    @(negedge clock);
    n_vec++;
    if ({a_b, busy_b, finish_b} !== '0) begin
      n_err++; $display("FAIL midrun_hold: got a=%h busy=%b fin=%b, want 0 0 0", a_b, busy_b, finish_b);
    end
    reset = 1'b1;
    repeat ($urandom_range(1, 3)) @(negedge clock);
    @(negedge clock) start_b = 1'b1;
    @(negedge clock) start_b = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      if (busy_b) busy_cycles++;
      if (k < 16) begin
        n_vec++;
        if (a_b !== va_b[k] || b_b !== vb_b[k]) begin
          n_err++; $display("FAIL rerun_vec k=%0d: got a=%h b=%h, want a=%h b=%h", k, a_b, b_b, va_b[k], vb_b[k]);
        end
      end
      @(negedge clock);
    end
    n_vec++;
    if (finish_b !== 1'b1 || fail_b !== 1'b0 || err_b !== 16'd0 || busy_cycles != 19) begin
      n_err++; $display("FAIL rerun_clean: got fin=%b fail=%b err=%0d busy=%0d, want 1 0 0 19",
                        finish_b, fail_b, err_b, busy_cycles);
    end
  endtask

  task automatic test_rerun_inject();
    int r1, r2;
    r1 = $urandom_range(0, 6);
    r2 = $urandom_range(8, 15);
    inj_b[r1] = 1'b1;
    inj_b[r2] = 1'b1;
    @(negedge clock) start_b = 1'b1;
    @(negedge clock) start_b = 1'b0;
    repeat (20) @(negedge clock);
    n_vec++;
    if (fail_b !== 1'b1 || err_b !== 16'd2 || idx_b !== 16'(r1) || finish_b !== 1'b1) begin
      n_err++; $display("FAIL inject_run1: got fail=%b err=%0d idx=%0d fin=%b, want 1 2 %0d 1",
                        fail_b, err_b, idx_b, finish_b, r1);
    end
    inj_b[r1] = 1'b0;
    inj_b[r2] = 1'b0;
    inj_b[7]  = 1'b1;
    repeat ($urandom_range(0, 3)) @(negedge clock);
    @(negedge clock) start_b = 1'b1;
    @(negedge clock) start_b = 1'b0;
    n_vec++;
    if (fail_b !== 1'b0 || err_b !== 16'd0 || idx_b !== 16'd0 || finish_b !== 1'b0) begin
      n_err++; $display("FAIL inject_clear: got fail=%b err=%0d idx=%0d fin=%b, want 0 0 0 0",
                        fail_b, err_b, idx_b, finish_b);
    end
    repeat (20) @(negedge clock);
    n_vec++;
    if (fail_b !== 1'b1 || err_b !== 16'd1 || idx_b !== 16'd7 || finish_b !== 1'b1) begin
      n_err++; $display("FAIL inject_run2: got fail=%b err=%0d idx=%0d fin=%b, want 1 1 7 1",
                        fail_b, err_b, idx_b, finish_b);
    end
    inj_b[7] = 1'b0;
  endtask

  initial begin
    build_model();
    test_reset();
    test_xnor_clean();
    test_xnor_inject();
    test_nand_lat3();
    test_wrong_latency();
    test_reset_midrun();
    test_rerun_inject();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/logic_vec_checker.md
# logic_vec_checker

Parametrised, synthesizable self-checking stimulus/checker for two-input bitwise logic units (and, or, xor, xnor, nand, nor) of any width and pipeline latency. It drives a directed first vector followed by LFSR-generated pseudo-random operand pairs into a DUT. It computes the golden result internally, aligns it to the DUT latency and compares. It reports sticky `fail`/`finish` plus an error count, which lets one CI harness cover every `<op>_iW_iW_iW` unit instead of one hand-written single-vector bench per unit.

## Interface
Parameters:
- `WIDTH`, 8: operand/result width, 1..32.
- `NUM_VEC`, 16: vectors per run, 1..65535.
- `LAT`, 0: DUT latency in cycles, 0..7 (0 = combinational DUT).
- `OP`, `OP_XNOR`: operation code from `logic_chk_pkg`.
- `A0`, 3: operand a of vector 0.
- `B0`, 12: operand b of vector 0.
- `SEED`, 32'hACE1_0001: LFSR seed; must be nonzero.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle run request.
- `a`  out  WIDTH  operand a to the DUT, registered.
- `b`  out  WIDTH  operand b to the DUT, registered.
- `y`  in  WIDTH  DUT result.
- `busy`  out  1  high in DRIVE or DRAIN.
- `fail`  out  1  sticky; at least one mismatch this run.
- `finish`  out  1  sticky; run complete.
- `err_count`  out  16  mismatches this run, saturating at 16'hFFFF.
- `first_err_idx`  out  16  index of the first mismatching vector; 0 when no mismatch.

## Operation
- FSM states: IDLE, DRIVE, DRAIN, DONE.
- IDLE→DRIVE on `start`. Entering DRIVE clears `fail`, `finish`, `err_count` and `first_err_idx`, and reloads the LFSR with `SEED`.
- DRIVE presents one vector per cycle and lasts exactly NUM_VEC cycles.
- DRIVE→DRAIN when LAT>0, or DRIVE→DONE when LAT=0, after vector NUM_VEC-1 is presented.
- DRAIN lasts LAT cycles, then goes to DONE.
- DONE→DRIVE on `start` (rerun). `start` in DRIVE or DRAIN is ignored.
- Vector 0 is {A0, B0} truncated to WIDTH.
- Vector i≥1 is `a=lfsr[WIDTH-1:0]`, `b=lfsr[31 -: WIDTH]`. The LFSR is a 32-bit Galois LFSR, polynomial 32'h8020_0003, stepped once per vector after vector 0.
- Golden result: `y_exp = f_OP(a,b)` at WIDTH bits, computed on the presented operands. It is carried with a valid bit and the vector index through a LAT-deep shift register.
- Compare: when the delayed valid bit is set, compare `y` against `y_exp`.
  - Mismatch sets `fail` and increments `err_count` (saturating).
  - On the first mismatch, `first_err_idx` captures the index.
- Outside DRIVE, `a` and `b` hold their last values. The DUT output is not compared once the pipeline is empty.

## Timing
- Reset values: state IDLE; `a`, `b`, `busy`, `fail`, `finish`, `err_count`, `first_err_idx` all 0; pipeline valid bits cleared; LFSR loaded with SEED.
- Edge numbering: `start` is sampled high at edge 0. Vector i is visible on `a`/`b` from edge i to edge i+1.
- Vector i is compared at edge i+1+LAT.
- `busy` is high from edge 0 until edge NUM_VEC+LAT.
- `finish` rises at edge NUM_VEC+LAT, in the same cycle as the final compare update.
- Simultaneous first mismatch and saturation cannot occur. Saturation holds at 16'hFFFF while `fail` stays 1.
- Reset asserted mid-run aborts immediately to reset values. No partial `finish` is produced.
- `start` held high through DONE restarts every cycle DONE is reached. Benches must pulse it.

## Structure
- `logic_chk_pkg` holds the following, shared by all generated harnesses:
  - `OP_AND`=0, `OP_OR`=1, `OP_XOR`=2, `OP_XNOR`=3, `OP_NAND`=4, `OP_NOR`=5.
  - State enum.
  - LFSR polynomial constant.
  - Golden function `logic_ref(op,a,b)`.
- One sub-module, `lfsr32`, with ports `clock`, `reset`, `load`, `seed`, `step`, `q`.
- The latency line is generated as a register array, or as a bypass when LAT=0.

## Test plan
- WIDTH=8, OP=XNOR, LAT=0, NUM_VEC=1, golden DUT: vector 0 gives y=8'hF0 (-16); `finish`=1 at edge 1; `fail`=0; `err_count`=0.
- Same setup with DUT output bit 0 forced to 1: `fail`=1, `err_count`=1, `first_err_idx`=0.
- WIDTH=32, OP=NAND, LAT=3, NUM_VEC=16, golden DUT: `busy` high for 19 cycles; `finish` at edge 19; `err_count`=0.
- LAT=2 with a DUT that actually has latency 1: vectors compare against the wrong results, so `fail`=1 and `err_count`≥14 of 16.
- Assert reset at edge 5 of a 16-vector run, then release and pulse `start`: all outputs are 0 during reset; the rerun reproduces the identical `a`/`b` sequence and finishes clean.
- Run, DONE, second `start` with a different injected error at vector 7: `err_count`=1 and `first_err_idx`=7, with counts from the first run cleared.
